piano_voice_bank: RTL
=====================

PIANO_VOICE_BANK -- requirements
Module: piano_voice_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tone channels, 1..8.
REQ-002 Parameter WIDTH_COUNTER, default 10: width of per-channel half-period counter and period register.
REQ-003 Parameter LEN_WIDTH, default 8: width of per-channel note-length counter.
REQ-004 Parameter PRESCALE, default 1000: clock cycles per note-length tick, >= 2.
REQ-005 Derived: CH_W = max(1, clog2(NUM_CH)); MIX_W = clog2(NUM_CH+1).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 cmd_valid  input  1  note command present.
REQ-009 cmd_ready  output  1  block can accept a command this cycle.
REQ-010 cmd_ch  input  CH_W  target channel index.
REQ-011 cmd_period  input  WIDTH_COUNTER  half-period minus one in clk cycles; 0 = note off.
REQ-012 cmd_len  input  LEN_WIDTH  note length in prescaler ticks; 0 = sustain until next command.
REQ-013 tone  output  NUM_CH  per-channel square wave.
REQ-014 active  output  NUM_CH  per-channel note-playing flag.
REQ-015 mix  output  MIX_W  number of tone bits currently high, registered.

Function
REQ-016 A command SHALL be accepted in any cycle where cmd_valid and cmd_ready are both 1.
REQ-017 cmd_ready SHALL be registered, go 0 in the cycle after an acceptance, and return to 1 one cycle later (max one command per 2 cycles).
REQ-018 Acceptance with cmd_ch >= NUM_CH SHALL be a no-op on all channels, with cmd_ready still following REQ-017.
REQ-019 On acceptance for channel c: period[c] <= cmd_period, len[c] <= cmd_len, cnt[c] <= 0, tone[c] <= 0, active[c] <= (cmd_period != 0).
REQ-020 While active[c]=1: cnt[c] increments each cycle; when cnt[c] == period[c], cnt[c] <= 0 and tone[c] toggles; full tone period = 2*(period+1) cycles.
REQ-021 First tone[c] rise SHALL occur period+1 cycles after the acceptance edge.
REQ-022 While active[c]=0: cnt[c] held 0, tone[c] held 0.
REQ-023 Prescaler: one shared free-running counter 0..PRESCALE-1, starting at 0 out of reset; tick asserted in the cycle it equals PRESCALE-1.
REQ-024 On tick, every channel with active=1 and len != 0 decrements len; a channel whose len goes 1 -> 0 SHALL clear active, tone and cnt on that same edge.
REQ-025 Channels with len = 0 at load (sustain) SHALL ignore ticks.
REQ-026 A command to channel c in the same cycle as its expiry or tone toggle SHALL take priority (REQ-019 wins).
REQ-027 Re-commanding an active channel SHALL restart it phase-aligned per REQ-019, with no glitch cycle at the old period.
REQ-028 mix SHALL equal popcount(tone) sampled on the previous edge (1-cycle latency).
REQ-029 Channels SHALL be fully independent apart from the shared prescaler and command port.

Reset
REQ-030 While rst_n=0, asynchronously: tone=0, active=0, mix=0, cmd_ready=0, all cnt/period/len=0, prescaler=0.
REQ-031 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-note SHALL silence all channels immediately without waiting for a clock edge.

Verification (NUM_CH=2, WIDTH_COUNTER=10, LEN_WIDTH=8, PRESCALE=4)
REQ-033 Reset release, then ch0 period=2 len=0 -> tone[0] high 3 cycles, low 3 cycles, repeating; first rise 3 cycles after accept; active[0]=1 throughout.
REQ-034 ch1 period=1 len=2 -> tone[1] toggles every 2 cycles, active[1] clears on the 2nd tick after accept (at most 8 cycles after accept), tone[1]=0 thereafter.
REQ-035 Back-to-back cmd_valid held 1 -> accept, cmd_ready=0 next cycle, accept again; ch0 period=5 then period=0 -> active[0]=0, tone[0]=0.
REQ-036 Both channels period=0x3, phase-aligned -> mix steps 0->2->0 with 1-cycle lag behind tone; cmd_ch=3 -> no channel state changes.
REQ-037 Command to ch1 in its expiry-tick cycle -> channel reloads and stays active; rst_n pulse low mid-note -> tone=0, mix=0 asynchronously, cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/piano_voice_bank.sv
// rtl/piano_voice_bank.sv - bank of independent square-wave tone channels with note-length timers
module piano_voice_bank #(
    parameter  int NUM_CH        = 4,
    parameter  int WIDTH_COUNTER = 10,
    parameter  int LEN_WIDTH     = 8,
    parameter  int PRESCALE      = 1000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W         = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [WIDTH_COUNTER-1:0] cmd_period,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic [NUM_CH-1:0]        tone,
    output logic [NUM_CH-1:0]        active,
    output logic [MIX_W-1:0]         mix
);

    localparam int PRE_W = $clog2(PRESCALE);

    logic                     cmd_ready_q, cmd_ready_d;
    logic [PRE_W-1:0]         pre_q, pre_d;
    logic [MIX_W-1:0]         mix_q, mix_d;
    logic [NUM_CH-1:0]        tone_q, tone_d;
    logic [NUM_CH-1:0]        active_q, active_d;
    logic [WIDTH_COUNTER-1:0] period_q [NUM_CH];
    logic [WIDTH_COUNTER-1:0] period_d [NUM_CH];
    logic [WIDTH_COUNTER-1:0] cnt_q    [NUM_CH];
    logic [WIDTH_COUNTER-1:0] cnt_d    [NUM_CH];
    logic [LEN_WIDTH-1:0]     len_q    [NUM_CH];
    logic [LEN_WIDTH-1:0]     len_d    [NUM_CH];
    logic                     accept;
    logic                     tick;

    always_comb begin
        accept      = cmd_valid && cmd_ready_q;
        cmd_ready_d = !accept;
        tick        = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d       = tick ? '0 : pre_q + PRE_W'(1);

        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + MIX_W'(tone_q[i]);
        end

        tone_d   = tone_q;
        active_d = active_q;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            len_d[i]    = len_q[i];
            // A new command overrides any toggle or expiry landing on the same edge.
            if (accept && (cmd_ch == CH_W'(i))) begin
                period_d[i] = cmd_period;
                len_d[i]    = cmd_len;
                cnt_d[i]    = '0;
                tone_d[i]   = 1'b0;
                active_d[i] = (cmd_period != '0);
            end else if (active_q[i]) begin
                if (cnt_q[i] == period_q[i]) begin
                    cnt_d[i]  = '0;
                    tone_d[i] = ~tone_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH_COUNTER'(1);
                end
                if (tick && (len_q[i] != '0)) begin
                    len_d[i] = len_q[i] - LEN_WIDTH'(1);
                    if (len_q[i] == LEN_WIDTH'(1)) begin
                        active_d[i] = 1'b0;
                        tone_d[i]   = 1'b0;
                        cnt_d[i]    = '0;
                    end
                end
            end else begin
                cnt_d[i]  = '0;
                tone_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            pre_q       <= '0;
            mix_q       <= '0;
            tone_q      <= '0;
            active_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
                len_q[i]    <= '0;
            end
        end else begin
            cmd_ready_q <= cmd_ready_d;
            pre_q       <= pre_d;
            mix_q       <= mix_d;
            tone_q      <= tone_d;
            active_q    <= active_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                len_q[i]    <= len_d[i];
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign tone      = tone_q;
    assign active    = active_q;
    assign mix       = mix_q;

endmodule
